// File: rtl/core_cache_resp.sv
// rtl/core_cache_resp.sv - direct-mapped write-through byte cache responder for the core/cache bus
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 16
`endif

module core_cache_resp #(
    parameter int ADDR_W = `ADDR_BUS_WIDTH,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hwrite,
    input  logic [7:0]        hwdata,
    input  logic              hreq,
    output logic              hgrant,
    output logic              hready,
    output logic [7:0]        hrdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int LINES = 1 << IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_RD,
        MEM_WR,
        RESP
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] req_addr;
    logic              req_write;
    logic [7:0]        req_wdata;
    logic              req_hit;
    logic [LINES-1:0]  valid;

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [7:0]        data_mem [LINES];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  req_tag;
    logic              lookup_hit;
    logic              ack_seen;

    assign idx        = req_addr[IDX_W-1:0];
    assign req_tag    = req_addr[ADDR_W-1:IDX_W];
    assign lookup_hit = valid[idx] && (tag_mem[idx] == req_tag);
    // An ack only counts while our request is outstanding.
    assign ack_seen   = mem_req && mem_ack;

    // Tag/data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (state == MEM_RD && ack_seen) begin
            data_mem[idx] <= mem_rdata;
            tag_mem[idx]  <= req_tag;
        end else if (state == MEM_WR && ack_seen && req_hit) begin
            data_mem[idx] <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hgrant    <= 1'b0;
            hready    <= 1'b0;
            hrdata    <= 8'h00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            req_addr  <= '0;
            req_write <= 1'b0;
            req_wdata <= 8'h00;
            req_hit   <= 1'b0;
            valid     <= '0;
        end else begin
            hgrant <= 1'b0;
            hready <= 1'b0;
            case (state)
                IDLE: begin
                    if (hreq) begin
                        req_addr  <= haddr;
                        req_write <= hwrite;
                        req_wdata <= hwdata;
                        hgrant    <= 1'b1;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    req_hit  <= lookup_hit;
                    mem_addr <= req_addr;
                    if (req_write) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_wdata <= req_wdata;
                        state     <= MEM_WR;
                    end else if (lookup_hit) begin
                        hrdata <= data_mem[idx];
                        hready <= 1'b1;
                        state  <= RESP;
                    end else begin
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                        state   <= MEM_RD;
                    end
                end
                MEM_RD: begin
                    if (ack_seen) begin
                        mem_req    <= 1'b0;
                        valid[idx] <= 1'b1;
                        hrdata     <= mem_rdata;
                        hready     <= 1'b1;
                        state      <= RESP;
                    end
                end
                MEM_WR: begin
                    if (ack_seen) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        hready  <= 1'b1;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_cache_resp.sv
// tb/tb_core_cache_resp.sv - scoreboard bench for core_cache_resp with a delay-programmable memory model
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 16
`endif

module tb_core_cache_resp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] haddr = '0;
    logic        hwrite = 1'b0;
    logic [7:0]  hwdata = '0;
    logic        hreq = 1'b0;
    logic        hgrant, hready;
    logic [7:0]  hrdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ack = 1'b0;

    core_cache_resp #(.ADDR_W(`ADDR_BUS_WIDTH), .IDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata), .hreq(hreq),
        .hgrant(hgrant), .hready(hready), .hrdata(hrdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_read;
        logic [7:0] data;
        int         lat;
    } resp_t;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } mem_t;

    resp_t       exp_q[$];
    mem_t        mem_q[$];
    logic [7:0]  mem_model [int];
    int          passed = 0;
    int          total = 0;
    int          cyc = 0;
    int          grant_cyc = 0;
    int          mem_delay = 0;
    bit          spurious = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] mrd(input logic [15:0] a);
        if (mem_model.exists(int'(a))) return mem_model[int'(a)];
        return 8'h00;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor
    resp_t mon_r;
    always @(negedge clk) begin
        if (hgrant && hready) chk(0, "grant_ready_overlap", 1, 0);
        if (hgrant) grant_cyc = cyc;
        if (hready) begin
            if (exp_q.size() == 0) begin
                chk(0, "resp_unexpected", hrdata, 0);
            end else begin
                mon_r = exp_q.pop_front();
                if (mon_r.is_read) chk(hrdata == mon_r.data, "hrdata", hrdata, mon_r.data);
                chk(cyc - grant_cyc == mon_r.lat, "latency", cyc - grant_cyc, mon_r.lat);
            end
        end
    end

    // Memory model and memory-side monitor
    initial begin : mem_proc
        int   cnt;
        bit   prev_ack;
        mem_t e;
        cnt = 0;
        prev_ack = 0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (prev_ack) chk(!mem_req, "mem_req_drop", mem_req, 0);
            prev_ack = 0;
            if (!rst_n) begin
                cnt = 0;
            end else if (mem_req) begin
                if (cnt >= mem_delay) begin
                    if (mem_q.size() == 0) begin
                        chk(0, "mem_unexpected", mem_addr, 0);
                    end else begin
                        e = mem_q.pop_front();
                        chk(mem_we == e.we, "mem_we", mem_we, e.we);
                        chk(mem_addr == e.addr, "mem_addr", mem_addr, e.addr);
                        if (e.we) chk(mem_wdata == e.wdata, "mem_wdata", mem_wdata, e.wdata);
                    end
                    if (mem_we) mem_model[int'(mem_addr)] = mem_wdata;
                    else mem_rdata = mrd(mem_addr);
                    mem_ack = 1'b1;
                    prev_ack = 1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
                if (spurious) begin
                    mem_ack = 1'b1;
                    spurious = 0;
                end
            end
        end
    end

    task automatic wait_ready();
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            seen = hready;
        end
        if (!seen) chk(0, "hready_timeout", 0, 1);
    endtask

    task automatic do_req(input logic [15:0] a, input bit w, input logic [7:0] wd,
                          input logic [7:0] exp_rd, input bit exp_hit, input int dly);
        resp_t r;
        mem_t  m;
        mem_delay = dly;
        r.is_read = !w;
        r.data    = exp_rd;
        r.lat     = (!w && exp_hit) ? 1 : dly + 2;
        exp_q.push_back(r);
        if (w || !exp_hit) begin
            m.we = w; m.addr = a; m.wdata = wd;
            mem_q.push_back(m);
        end
        haddr = a; hwrite = w; hwdata = wd; hreq = 1'b1;
        @(posedge clk); #1;
        chk(hgrant == 1'b1, "grant", hgrant, 1);
        hreq = 1'b0;
        wait_ready();
        @(posedge clk); #1;
    endtask

    initial begin
        mem_model[16'h0020] = 8'h11;
        mem_model[16'h0012] = 8'hA5;
        mem_model[16'h0022] = 8'hC3;
        mem_model[16'h0102] = 8'h5A;
        mem_model[16'h0050] = 8'h99;
        mem_model[16'h0034] = 8'hEE;

        // Reset held with a pending request
        haddr = 16'h0020; hwrite = 1'b0; hreq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(hgrant == 0, "rst_hgrant", hgrant, 0);
            chk(hready == 0, "rst_hready", hready, 0);
            chk(mem_req == 0, "rst_mem_req", mem_req, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_req(16'h0020, 0, 8'h00, 8'h11, 0, 2);

        do_req(16'h0012, 0, 8'h00, 8'hA5, 0, 3);
        do_req(16'h0012, 0, 8'h00, 8'hA5, 1, 0);
        do_req(16'h0012, 1, 8'h3C, 8'h00, 1, 1);
        do_req(16'h0012, 0, 8'h00, 8'h3C, 1, 0);
        do_req(16'h0034, 1, 8'h77, 8'h00, 0, 0);
        spurious = 1;
        do_req(16'h0034, 0, 8'h00, 8'h77, 0, 2);
        do_req(16'h0034, 0, 8'h00, 8'h77, 1, 0);

        // Index 2 aliasing
        do_req(16'h0022, 0, 8'h00, 8'hC3, 0, 1);
        do_req(16'h0012, 0, 8'h00, 8'h3C, 0, 0);
        do_req(16'h0102, 0, 8'h00, 8'h5A, 0, 4);
        do_req(16'h0012, 0, 8'h00, 8'h3C, 0, 1);
        do_req(16'h0102, 1, 8'h66, 8'h00, 0, 0);
        do_req(16'h0012, 0, 8'h00, 8'h3C, 1, 0);

        // Reset while a fill is outstanding
        mem_delay = 8;
        haddr = 16'h0050; hwrite = 1'b0; hreq = 1'b1;
        @(posedge clk); #1;
        chk(hgrant == 1'b1, "grant_abort", hgrant, 1);
        hreq = 1'b0;
        @(posedge clk); #1;
        chk(mem_req == 1'b1, "mem_req_rise", mem_req, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk(mem_req == 1'b0, "mem_req_async_drop", mem_req, 0);
        chk(hready == 1'b0, "hready_in_reset", hready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(16'h0050, 0, 8'h00, 8'h99, 0, 1);
        do_req(16'h0050, 0, 8'h00, 8'h99, 1, 0);
        do_req(16'h0012, 0, 8'h00, 8'h3C, 0, 0);

        repeat (3) @(posedge clk);
        chk(exp_q.size() == 0, "resp_outstanding", exp_q.size(), 0);
        chk(mem_q.size() == 0, "mem_outstanding", mem_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/core_cache_resp.md
# core_cache_resp

Cache-side responder for the core/cache byte bus: accepts one core request at a time via the hreq/hgrant/hready handshake and serves it from a direct-mapped, write-through, no-write-allocate byte cache. Misses and all writes go through a simple req/ack memory port. The block sits between the core's core-side bus port and the backing memory model in the lab cache environment.

## Interface
- ADDR_W, 16: core and memory address width; instantiate with `ADDR_BUS_WIDTH.
- IDX_W, 4: index width; 2**IDX_W lines of one byte each; tag = haddr[ADDR_W-1:IDX_W].
- clk  in  1  the single clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- haddr  in  ADDR_W  request address, sampled with hreq.
- hwrite  in  1  1 = write, 0 = read.
- hwdata  in  8  write byte.
- hreq  in  1  core request.
- hgrant  out  1  one-cycle pulse: request latched.
- hready  out  1  one-cycle pulse: request complete.
- hrdata  out  8  read byte, valid while hready=1 for a read.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  8  memory write byte.
- mem_rdata  in  8  memory read byte, valid with mem_ack.
- mem_ack  in  1  memory completion, one-cycle pulse.

## Operation
- States: IDLE, LOOKUP, MEM_RD, MEM_WR, RESP.
- IDLE: when hreq=1 is sampled, latch haddr/hwrite/hwdata, assert hgrant next cycle, go to LOOKUP. hreq is ignored in every other state.
- LOOKUP: hit = valid[idx] && tag[idx]==latched tag.
  - Read hit: go to RESP, hrdata <= data[idx].
  - Read miss: go to MEM_RD.
  - Write (hit or miss): go to MEM_WR.
- MEM_RD: mem_req=1, mem_we=0, mem_addr=latched addr. On mem_ack, fill the line: data <= mem_rdata, tag <= latched tag, valid <= 1. Then hrdata <= mem_rdata, go to RESP.
- MEM_WR: mem_req=1, mem_we=1, mem_wdata=latched hwdata. On mem_ack, update data[idx] if the lookup was a hit (valid/tag unchanged); a miss allocates nothing. Go to RESP.
- RESP: hready=1 for one cycle, then IDLE.
- Reset values: all outputs 0, state IDLE, all valid bits 0. Tag and data arrays are not reset.
- Reset mid-operation: asynchronous return to IDLE, mem_req drops immediately, any in-flight fill is discarded.
- Index aliasing: a read miss evicts the resident line unconditionally. Write-through means no dirty state and no writeback.

## Timing
- All outputs are registered; none depend combinationally on inputs.
- Core rules:
  - Core holds hreq and request fields stable until it samples hgrant=1, then drops hreq.
  - Next request is issued no earlier than the cycle after hready.
- Read hit: hreq sampled at edge E; hgrant high in cycle E+1; hready and hrdata in cycle E+2.
- Miss or write:
  - mem_req rises in cycle E+2 and stays high, with stable address/data, until mem_ack is sampled.
  - mem_req falls the cycle after mem_ack.
  - hready is asserted in the cycle after the mem_ack cycle.
- mem_ack on the same cycle mem_req first rises is legal (zero-wait memory).
- mem_ack while mem_req=0 is ignored.
- Back-to-back requests: hreq sampled in the IDLE cycle right after RESP is accepted. Minimum request spacing is 3 cycles on hits.
- hgrant and hready are never high in the same cycle.

## Test plan
- Reset: hold rst_n=0 with hreq=1 -> hgrant, hready, mem_req all 0. Release -> request granted one cycle later.
- Cold read of 0x0012, memory returns 0xA5 after 3 cycles -> one mem read at 0x0012, hrdata=0xA5 with hready. Re-read -> hit, hready at E+2, no mem_req.
- Write 0x3C to 0x0012 (resident) -> mem write at 0x0012/0x3C. Next read returns 0x3C with no mem_req.
- Write 0x77 to 0x0034 (absent) -> mem write only. Following read of 0x0034 misses and issues a mem read.
- Aliasing with IDX_W=4: read 0x0012, then 0x0102, then 0x0012 -> three misses, each with its own mem read.
- Assert rst_n=0 while in MEM_RD -> mem_req drops asynchronously. After release, a read of the same address misses (no stale fill).
